// File: rtl/trng_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : trng_pkg
// | Brief    : Shared defaults and FSM state encoding for the TRNG comparator.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
package trng_pkg;

   localparam int c_n_osc_default = 4;
   localparam int c_cnt_w_default = 16;
   localparam int c_win_default   = 1024;

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_armed = 2'd1;
   localparam logic [1:0] c_st_run   = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = c_st_idle,
      ST_ARMED = c_st_armed,
      ST_RUN   = c_st_run,
      ST_DONE  = c_st_done
   } state_e;

endpackage
`default_nettype wire

// File: rtl/trng_sync_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : trng_sync_edge
// | Brief    : 2-FF synchronizer plus rising-edge detector for one async bit.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
module trng_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic d_async,
   output logic pulse
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = d_async;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign pulse = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/trng_cmp.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : trng_cmp
// | Brief    : Counts edges of one selected oscillator pair over a fixed window
// |            and emits the parity of the two counts as a raw random bit.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
module trng_cmp
   import trng_pkg::*;
#(
   parameter int N_OSC = c_n_osc_default,
   parameter int CNT_W = c_cnt_w_default,
   parameter int WIN   = c_win_default
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_OSC-1:0]         osc_a,
   input  logic [N_OSC-1:0]         osc_b,
   input  logic                     cmp_inc,
   input  logic                     cmp_rst,
   input  logic                     cmp_str,
   input  logic                     cmp_cap,
   output logic                     cmp_end,
   output logic                     rnd_bit,
   output logic                     rnd_valid,
   output logic [$clog2(N_OSC)-1:0] pair_sel
);

   localparam int c_sel_w = $clog2(N_OSC);
   localparam int c_win_w = $clog2(WIN);
   localparam logic [c_sel_w-1:0] c_sel_last = c_sel_w'(N_OSC - 1);
   localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WIN - 1);

   logic [N_OSC-1:0] w_pulse_a;
   logic [N_OSC-1:0] w_pulse_b;
   logic             w_sel_a;
   logic             w_sel_b;

   state_e               state_q,     state_d;
   logic [c_sel_w-1:0]   pair_sel_q,  pair_sel_d;
   logic [CNT_W-1:0]     cnt_a_q,     cnt_a_d;
   logic [CNT_W-1:0]     cnt_b_q,     cnt_b_d;
   logic [c_win_w-1:0]   win_cnt_q,   win_cnt_d;
   logic                 cmp_end_q,   cmp_end_d;
   logic                 rnd_bit_q,   rnd_bit_d;
   logic                 rnd_valid_q, rnd_valid_d;

   for (genvar i = 0; i < N_OSC; i++) begin : g_osc
      trng_sync_edge u_sync_a (
         .clock   (clock),
         .reset   (reset),
         .d_async (osc_a[i]),
         .pulse   (w_pulse_a[i])
      );
      trng_sync_edge u_sync_b (
         .clock   (clock),
         .reset   (reset),
         .d_async (osc_b[i]),
         .pulse   (w_pulse_b[i])
      );
   end

   assign w_sel_a = w_pulse_a[pair_sel_q];
   assign w_sel_b = w_pulse_b[pair_sel_q];

   always_comb begin
      state_d     = state_q;
      pair_sel_d  = pair_sel_q;
      cnt_a_d     = cnt_a_q;
      cnt_b_d     = cnt_b_q;
      win_cnt_d   = win_cnt_q;
      rnd_bit_d   = rnd_bit_q;
      rnd_valid_d = 1'b0;

      // cmp_rst overrides every other command and leaves pair_sel untouched
      if (cmp_rst) begin
         state_d   = ST_ARMED;
         cnt_a_d   = '0;
         cnt_b_d   = '0;
         win_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmp_inc) begin
                  pair_sel_d = (pair_sel_q == c_sel_last) ? '0 : pair_sel_q + 1'b1;
               end
            end
            ST_ARMED: begin
               if (cmp_str) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_sel_a && (cnt_a_q != '1)) begin
                  cnt_a_d = cnt_a_q + 1'b1;
               end
               if (w_sel_b && (cnt_b_q != '1)) begin
                  cnt_b_d = cnt_b_q + 1'b1;
               end
               if (win_cnt_q == c_win_last) begin
                  state_d = ST_DONE;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (cmp_cap) begin
                  rnd_bit_d   = cnt_a_q[0] ^ cnt_b_q[0];
                  rnd_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      cmp_end_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pair_sel_q  <= '0;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         win_cnt_q   <= '0;
         cmp_end_q   <= 1'b0;
         rnd_bit_q   <= 1'b0;
         rnd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pair_sel_q  <= pair_sel_d;
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
         win_cnt_q   <= win_cnt_d;
         cmp_end_q   <= cmp_end_d;
         rnd_bit_q   <= rnd_bit_d;
         rnd_valid_q <= rnd_valid_d;
      end
   end

   assign cmp_end   = cmp_end_q;
   assign rnd_bit   = rnd_bit_q;
   assign rnd_valid = rnd_valid_q;
   assign pair_sel  = pair_sel_q;

endmodule
`default_nettype wire
